// File: rtl/multdiv_defs_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// iteration count and the rstatus codes the execute stage writes on exception.
package multdiv_defs;

  localparam int MD_ITER  = 32;
  localparam int MULT_EXC = 4;
  localparam int DIV_EXC  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/multdiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface multdiv_if
  import multdiv_defs::*;
#(
  parameter int WIDTH = MD_ITER
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_counter.sv
// Iteration counter: cleared on a start edge, counts while enabled and
// stops at WIDTH, where done is asserted.
module multdiv_counter
  import multdiv_defs::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [5:0] count;

  assign done = (count == 6'(WIDTH));

  // NOTE: reset is sampled only at the clock edge, so it is tested inside the
  // edge-triggered block rather than listed in the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset)              count <= '0;
    else if (load)           count <= '0;
    else if (en && !done)    count <= count + 6'd1;
  end
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a final sign fix-up.
module multdiv_unit
  import multdiv_defs::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic     clock,
  input  logic     reset,
  multdiv_if.slave bus
);
  md_state_t        state;
  logic             sign;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] hi, lo;
  logic             cnt_done;

  logic             start;
  logic [WIDTH-1:0] a_in_mag, b_in_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod_signed;
  logic             mul_exc;
  logic [WIDTH-1:0] quot_signed;
  logic             div_exc;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  multdiv_counter #(.WIDTH(WIDTH)) u_counter (
    .clock (clock),
    .reset (reset),
    .load  (start),
    .en    ((state == MULT) || (state == DIV)),
    .done  (cnt_done)
  );

  // NOTE: every signal driven here gets an unconditional assignment, so no
  // latch can be inferred.
  always_comb begin
    a_in_mag    = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
    b_in_mag    = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;
    // Multiply: hi accumulates partial sums, lo shifts the multiplier out.
    mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    div_shift   = {hi, lo[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, b_mag});
    div_sub     = div_shift[WIDTH-1:0] - b_mag;
    prod_signed = sign ? -{hi, lo} : {hi, lo};
    mul_exc     = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    quot_signed = sign ? -lo : lo;
    // Only a positive quotient of magnitude 2^(WIDTH-1) overflows (MIN / -1).
    div_exc     = !sign && lo[WIDTH-1];
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= IDLE;
      sign               <= 1'b0;
      a_mag              <= '0;
      b_mag              <= '0;
      hi                 <= '0;
      lo                 <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b0;
    end else if (start) begin
      sign               <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      a_mag              <= a_in_mag;
      b_mag              <= b_in_mag;
      hi                 <= '0;
      lo                 <= bus.ctrl_MULT ? b_in_mag : a_in_mag;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy           <= 1'b1;
      if (bus.ctrl_MULT) begin
        state <= MULT;
      end else if (bus.data_operandB == '0) begin
        state              <= DONE;
        bus.data_exception <= 1'b1;
        bus.data_resultRDY <= 1'b1;
        bus.busy           <= 1'b0;
      end else begin
        state <= DIV;
      end
    end else begin
      case (state)
        MULT: begin
          if (cnt_done) begin
            state              <= DONE;
            bus.data_result    <= prod_signed[WIDTH-1:0];
            bus.data_exception <= mul_exc;
            bus.data_resultRDY <= 1'b1;
            bus.busy           <= 1'b0;
          end else begin
            {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
          end
        end
        DIV: begin
          if (cnt_done) begin
            state              <= DONE;
            bus.data_result    <= quot_signed;
            bus.data_exception <= div_exc;
            bus.data_resultRDY <= 1'b1;
            bus.busy           <= 1'b0;
          end else begin
            hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end
        end
        DONE: begin
          state              <= IDLE;
          bus.data_resultRDY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
